// File: rtl/decoder_grant_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// decoder_grant_arbiter_pkg
//
// Shared definitions for the round-robin grant arbiter and its one-hot decoder:
//   - N_REQ / IDX_W : number of requesters and width of a requester index
//   - HOLD_W        : width of the hold counter (covers HOLD_MAX up to 255)
//   - arb_state_e   : FSM state encoding (IDLE=0, GRANT=1, RELEASE=2)
//   - idx_inc()     : circular "next requester" helper (7 wraps to 0)
// -----------------------------------------------------------------------------
package decoder_grant_arbiter_pkg;

    localparam int N_REQ  = 8;
    localparam int IDX_W  = 3;
    localparam int HOLD_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    // The index width is exactly log2(N_REQ), so plain 3-bit addition gives
    // the circular 7 -> 0 wrap without an explicit modulo.
    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
        return idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/decoder_grant_arbiter_decoder.sv
// -----------------------------------------------------------------------------
// decoder_1hot_3to8
//
// Pure combinational binary-to-one-hot decoder.
//
// Ports:
//   idx    in  [IDX_W-1:0]  binary index
//   onehot out [N_REQ-1:0]  bit idx set, all others clear
// -----------------------------------------------------------------------------
module decoder_1hot_3to8
    import decoder_grant_arbiter_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output logic [N_REQ-1:0] onehot
);

    always_comb begin
        // NOTE: every signal driven from always_comb gets a default on entry;
        // otherwise any path that skips an assignment infers a latch.
        onehot      = '0;
        onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/decoder_grant_arbiter.sv
// -----------------------------------------------------------------------------
// decoder_grant_arbiter
//
// Eight-requester round-robin arbiter with a bounded hold time.
//
// A grant is issued one clock after a request is seen (when en=1), searching
// circularly from the requester after the last one served. The holder keeps
// the grant while its request stays high, for at most HOLD_MAX cycles. Every
// grant is followed by exactly one dead RELEASE cycle; when the grant was cut
// off by the hold limit while still requested, preempt pulses in that cycle.
// en only gates new selections -- it never aborts a grant in progress.
//
// Parameters:
//   HOLD_MAX   maximum consecutive grant cycles per requester (1..255)
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   req        in   [7:0] request vector, bit i = requester i
//   en         in   arbitration enable (gates new grants only)
//   gnt        out  [7:0] one-hot grant, zero when no grant is active
//   gnt_idx    out  [2:0] index of the current / most recent grantee
//   gnt_valid  out  high while a grant is active
//   preempt    out  one-cycle pulse when a grant ended on the hold limit
// -----------------------------------------------------------------------------
module decoder_grant_arbiter
    import decoder_grant_arbiter_pkg::*;
#(
    parameter int HOLD_MAX = 15
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             en,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             preempt
);

    arb_state_e        state;
    logic [IDX_W-1:0]  ptr;        // where the next circular search starts
    logic [HOLD_W-1:0] hold_cnt;   // cycles the current grantee has held

    logic              sel_hit;
    logic [IDX_W-1:0]  sel_idx;
    logic              hold_at_max;
    logic              owner_req;
    logic [N_REQ-1:0]  dec_onehot;

    // First set request bit at or after start, wrapping 7 -> 0. Returns
    // {found, index}; index is don't-care when found is 0.
    function automatic logic [IDX_W:0] find_next(
        input logic [N_REQ-1:0] r,
        input logic [IDX_W-1:0] start
    );
        logic             found;
        logic [IDX_W-1:0] pick;
        logic [IDX_W-1:0] cand;
        found = 1'b0;
        pick  = start;
        for (int i = 0; i < N_REQ; i++) begin
            cand = start + IDX_W'(i);
            if (!found && r[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        return {found, pick};
    endfunction

    assign {sel_hit, sel_idx} = find_next(req, ptr);
    assign owner_req          = req[gnt_idx];
    assign hold_at_max        = (hold_cnt == HOLD_W'(HOLD_MAX));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // Reset drops any live grant at this very edge; no RELEASE cycle.
            state     <= IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            preempt   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            preempt <= 1'b0;
            case (state)
                IDLE, RELEASE: begin
                    // A RELEASE cycle may chain straight into the next grant,
                    // which keeps the gap between grants at exactly one cycle.
                    if (en && sel_hit) begin
                        state     <= GRANT;
                        gnt_idx   <= sel_idx;
                        hold_cnt  <= HOLD_W'(1);
                        gnt_valid <= 1'b1;
                    end else begin
                        state     <= IDLE;
                        gnt_valid <= 1'b0;
                    end
                end

                GRANT: begin
                    if (!owner_req || hold_at_max) begin
                        state     <= RELEASE;
                        gnt_valid <= 1'b0;
                        hold_cnt  <= '0;
                        ptr       <= idx_inc(gnt_idx);
                        // Only a limit-hit with the request still high counts
                        // as a preemption; a drop on the last cycle is normal.
                        preempt   <= owner_req;
                    end else begin
                        hold_cnt  <= hold_cnt + HOLD_W'(1);
                    end
                end

                default: begin
                    state     <= IDLE;
                    gnt_valid <= 1'b0;
                end
            endcase
        end
    end

    // Grant vector is a decode of the registered index, gated by the
    // registered valid, so it carries no combinational path from req.
    decoder_1hot_3to8 u_dec (
        .idx    (gnt_idx),
        .onehot (dec_onehot)
    );

    assign gnt = gnt_valid ? dec_onehot : '0;

endmodule

// File: tb/tb_decoder_grant_arbiter.sv
// -----------------------------------------------------------------------------
// tb_decoder_grant_arbiter
//
// Four arbiters with HOLD_MAX = 1, 2, 4 and 15 share one stimulus stream.
// A directed vector table and hand-written sequences check fixed expectations;
// a behavioural model (owner / cycles-held / next-start bookkeeping) is
// compared against every instance on every clock.
// -----------------------------------------------------------------------------
module tb_decoder_grant_arbiter;

    localparam int N_DUT = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       en;

    logic [7:0] gnt_a [N_DUT];
    logic [2:0] idx_a [N_DUT];
    logic       vld_a [N_DUT];
    logic       pre_a [N_DUT];

    int total = 0;
    int bad   = 0;

    function automatic int hm_of(input int k);
        case (k)
            0:       return 1;
            1:       return 2;
            2:       return 4;
            default: return 15;
        endcase
    endfunction

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        localparam int HM = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 15;
        decoder_grant_arbiter #(.HOLD_MAX(HM)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .req       (req),
            .en        (en),
            .gnt       (gnt_a[g]),
            .gnt_idx   (idx_a[g]),
            .gnt_valid (vld_a[g]),
            .preempt   (pre_a[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit m_active [N_DUT];
    int m_owner  [N_DUT];
    int m_count  [N_DUT];
    int m_next   [N_DUT];
    bit m_pre    [N_DUT];

    function automatic int pick(input logic [7:0] r, input int start);
        for (int d = 0; d < 8; d++) begin
            if (r[(start + d) % 8]) return (start + d) % 8;
        end
        return start;
    endfunction

    task automatic model_edge(input logic r_n, input logic [7:0] r, input logic e);
        for (int k = 0; k < N_DUT; k++) begin
            if (!r_n) begin
                m_active[k] = 0; m_owner[k] = 0; m_count[k] = 0;
                m_next[k] = 0;   m_pre[k] = 0;
            end else if (m_active[k]) begin
                if (!r[m_owner[k]] || m_count[k] == hm_of(k)) begin
                    m_pre[k]    = r[m_owner[k]];
                    m_active[k] = 0;
                    m_next[k]   = (m_owner[k] + 1) % 8;
                end else begin
                    m_count[k]++;
                end
            end else begin
                m_pre[k] = 0;
                if (e && r != 8'h00) begin
                    m_owner[k]  = pick(r, m_next[k]);
                    m_active[k] = 1;
                    m_count[k]  = 1;
                end
            end
        end
    endtask

    function automatic logic [31:0] pack_exp(input logic v, input logic [2:0] idx, input logic p);
        logic [7:0] g;
        g = v ? (8'h01 << idx) : 8'h00;
        return {19'd0, g, idx, v, p};
    endfunction

    function automatic logic [31:0] pack_act(input int k);
        return {19'd0, gnt_a[k], idx_a[k], vld_a[k], pre_a[k]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got {gnt,idx,valid,preempt}=%h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply inputs, clock once, then compare every instance with the model.
    task automatic step(input logic r_n, input logic [7:0] r, input logic e);
        rst_n = r_n;
        req   = r;
        en    = e;
        @(posedge clk);
        model_edge(r_n, r, e);
        #1;
        for (int k = 0; k < N_DUT; k++) begin
            check($sformatf("model_hm%0d", hm_of(k)), pack_act(k),
                  pack_exp(m_active[k], 3'(m_owner[k]), m_pre[k]));
        end
    endtask

    // ---------------- directed vector table (HOLD_MAX=15 instance) ----------------
    typedef struct {
        logic       rst_n;
        logic [7:0] req;
        logic       en;
        logic       v;
        logic [2:0] idx;
        logic       pre;
    } vec_t;

    vec_t tbl [17];

    initial begin
        logic [7:0] r;

        rst_n = 1'b0;
        req   = 8'h00;
        en    = 1'b0;

        tbl[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0}; // reset state
        tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0};
        tbl[2]  = '{1'b1, 8'h01, 1'b1, 1'b1, 3'd0, 1'b0}; // one-cycle latency
        tbl[3]  = '{1'b1, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0}; // dead cycle
        tbl[4]  = '{1'b1, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0}; // idle
        tbl[5]  = '{1'b1, 8'h08, 1'b1, 1'b1, 3'd3, 1'b0}; // grant 3
        tbl[6]  = '{1'b1, 8'h08, 1'b0, 1'b1, 3'd3, 1'b0}; // en=0 keeps grant
        tbl[7]  = '{1'b1, 8'h0C, 1'b0, 1'b1, 3'd3, 1'b0};
        tbl[8]  = '{1'b1, 8'h04, 1'b0, 1'b0, 3'd3, 1'b0}; // req[3] drops
        tbl[9]  = '{1'b1, 8'h04, 1'b0, 1'b0, 3'd3, 1'b0}; // en=0 blocks new
        tbl[10] = '{1'b1, 8'h04, 1'b0, 1'b0, 3'd3, 1'b0};
        tbl[11] = '{1'b1, 8'h04, 1'b1, 1'b1, 3'd2, 1'b0}; // search from 4 wraps to 2
        tbl[12] = '{1'b1, 8'h04, 1'b1, 1'b1, 3'd2, 1'b0};
        tbl[13] = '{1'b0, 8'h04, 1'b1, 1'b0, 3'd0, 1'b0}; // reset mid-grant
        tbl[14] = '{1'b1, 8'h80, 1'b1, 1'b1, 3'd7, 1'b0}; // grant 7 after reset
        tbl[15] = '{1'b1, 8'h00, 1'b1, 1'b0, 3'd7, 1'b0};
        tbl[16] = '{1'b1, 8'h00, 1'b1, 1'b0, 3'd7, 1'b0};

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].rst_n, tbl[i].req, tbl[i].en);
            check($sformatf("table_row%0d", i), pack_act(3),
                  pack_exp(tbl[i].v, tbl[i].idx, tbl[i].pre));
        end

        // ---- HOLD_MAX=2, all requesting: 0..7,0 for 2 cycles each with preempt ----
        step(1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 9; k++) begin
            step(1'b1, 8'hFF, 1'b1);
            check($sformatf("rr_hold_a_%0d", k), pack_act(1), pack_exp(1'b1, 3'(k % 8), 1'b0));
            step(1'b1, 8'hFF, 1'b1);
            check($sformatf("rr_hold_b_%0d", k), pack_act(1), pack_exp(1'b1, 3'(k % 8), 1'b0));
            step(1'b1, 8'hFF, 1'b1);
            check($sformatf("rr_preempt_%0d", k), pack_act(1), pack_exp(1'b0, 3'(k % 8), 1'b1));
        end

        // ---- pointer at 5 with req=21: 5 first, then 0 ----
        step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h10, 1'b1);
        check("ptr5_grant4", pack_act(3), pack_exp(1'b1, 3'd4, 1'b0));
        step(1'b1, 8'h21, 1'b1);
        check("ptr5_release", pack_act(3), pack_exp(1'b0, 3'd4, 1'b0));
        step(1'b1, 8'h21, 1'b1);
        check("ptr5_grant5", pack_act(3), pack_exp(1'b1, 3'd5, 1'b0));
        step(1'b1, 8'h01, 1'b1);
        check("ptr5_release5", pack_act(3), pack_exp(1'b0, 3'd5, 1'b0));
        step(1'b1, 8'h01, 1'b1);
        check("ptr5_grant0", pack_act(3), pack_exp(1'b1, 3'd0, 1'b0));

        // ---- HOLD_MAX=4: drop exactly at the limit is a normal release ----
        step(1'b0, 8'h00, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            step(1'b1, 8'h04, 1'b1);
            check($sformatf("hm4_hold%0d", c), pack_act(2), pack_exp(1'b1, 3'd2, 1'b0));
        end
        step(1'b1, 8'h00, 1'b1);
        check("hm4_drop_at_max", pack_act(2), pack_exp(1'b0, 3'd2, 1'b0));

        // ---- HOLD_MAX=4: still requesting at the limit is a preemption ----
        step(1'b0, 8'h00, 1'b0);
        for (int c = 1; c <= 4; c++) step(1'b1, 8'h04, 1'b1);
        step(1'b1, 8'h04, 1'b1);
        check("hm4_preempt", pack_act(2), pack_exp(1'b0, 3'd2, 1'b1));
        step(1'b1, 8'h04, 1'b1);
        check("hm4_regrant", pack_act(2), pack_exp(1'b1, 3'd2, 1'b0));

        // ---------------- randomized phase against the model ----------------
        r = 8'h00;
        for (int n = 0; n < 4000; n++) begin
            logic rr_n;
            logic ee;
            rr_n = ($urandom_range(0, 99) != 0);
            ee   = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 9) < 3) begin
                r = 8'($urandom);
                if ($urandom_range(0, 2) == 0) r = r & 8'($urandom);
            end
            step(rr_n, r, ee);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
